// File: rtl/treeval_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : treeval_cmd_issuer
// Purpose  : Host-side initiator for the treeval 64-bit command-message link.
//            Walks a node table, serializes it into SET_CONFIG, SET_NODE and
//            RUN messages over a rdy/ack handshake, then waits for the
//            controller's result message (with a timeout), acknowledges it
//            and presents the chosen action and expected reward.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            start, num_nodes  - sequence request and node count
//            node_rd_*         - node-table read port (1-cycle latency)
//            node_par/rew/act/wgt - node fields returned by the table
//            cmd_msg/rdy/ack   - outbound command message handshake
//            res_msg/rdy/ack   - inbound result message handshake
//            busy, done, err   - sequence status
//            result_act/rew    - captured result
// Revision : 1.0 - initial release
// ============================================================================
module treeval_cmd_issuer #(
    parameter int W_MSG    = 64,
    parameter int W_ADDR   = 10,
    parameter int W_REWARD = 10,
    parameter int W_ACTION = 3,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W_ADDR-1:0]   num_nodes,
    output logic                node_rd_en,
    output logic [W_ADDR-1:0]   node_rd_addr,
    input  logic [W_ADDR-1:0]   node_par,
    input  logic [W_REWARD-1:0] node_rew,
    input  logic [W_ACTION-1:0] node_act,
    input  logic [W_REWARD-1:0] node_wgt,
    output logic [W_MSG-1:0]    cmd_msg,
    output logic                cmd_rdy,
    input  logic                cmd_ack,
    input  logic [W_MSG-1:0]    res_msg,
    input  logic                res_rdy,
    output logic                res_ack,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [W_ACTION-1:0] result_act,
    output logic [W_REWARD-1:0] result_rew
);

    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] c_IDLE       = 3'd0;
    localparam logic [2:0] c_SEND_CFG   = 3'd1;
    localparam logic [2:0] c_FETCH      = 3'd2;
    localparam logic [2:0] c_LATCH      = 3'd3;
    localparam logic [2:0] c_SEND_FIELD = 3'd4;
    localparam logic [2:0] c_SEND_RUN   = 3'd5;
    localparam logic [2:0] c_WAIT_RES   = 3'd6;
    localparam logic [2:0] c_DONE       = 3'd7;

    localparam logic [1:0] c_CMD_RUN  = 2'd0;
    localparam logic [1:0] c_CMD_NODE = 2'd1;
    localparam logic [1:0] c_CMD_CFG  = 2'd2;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [W_ADDR-1:0]   r_num;
    logic [W_ADDR-1:0]   r_idx;
    logic [1:0]          r_fld;
    logic [W_ADDR-1:0]   r_par;
    logic [W_REWARD-1:0] r_rew;
    logic [W_ACTION-1:0] r_act;
    logic [W_REWARD-1:0] r_wgt;
    logic [W_MSG-1:0]    r_cmd_msg;
    logic                r_cmd_rdy;
    logic                r_res_ack;
    logic                r_err;
    logic [W_ACTION-1:0] r_res_act;
    logic [W_REWARD-1:0] r_res_rew;
    logic [c_TW-1:0]     r_tcnt;

    logic                w_send_st;
    logic                w_cmd_fire;
    logic                w_res_take;
    logic                w_tmo;
    logic                w_last;
    logic [W_REWARD-1:0] w_fval;
    logic [W_MSG-1:0]    w_msg;
    logic                w_unused_res;

    // Only the action and reward bits of the result message are meaningful.
    assign w_unused_res = ^res_msg[W_MSG-1:W_ACTION+W_REWARD];

    assign w_send_st  = (r_state == c_SEND_CFG) || (r_state == c_SEND_FIELD) ||
                        (r_state == c_SEND_RUN);
    assign w_cmd_fire = r_cmd_rdy & cmd_ack;
    // r_res_ack guard keeps a held res_rdy from being taken twice.
    assign w_res_take = (r_state == c_WAIT_RES) & res_rdy & ~r_res_ack;
    assign w_tmo      = (r_state == c_WAIT_RES) & ~res_rdy &
                        (r_tcnt == c_TW'(TIMEOUT - 1));
    // Last-node test avoids incrementing idx past num_nodes-1 (no wrap at 1023).
    assign w_last     = (r_idx == r_num - W_ADDR'(1));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:       if (start) w_state_nxt = c_SEND_CFG;
            c_SEND_CFG:   if (w_cmd_fire) w_state_nxt = (r_num != '0) ? c_FETCH : c_SEND_RUN;
            c_FETCH:      w_state_nxt = c_LATCH;
            c_LATCH:      w_state_nxt = c_SEND_FIELD;
            c_SEND_FIELD: if (w_cmd_fire && (r_fld == 2'd3))
                              w_state_nxt = w_last ? c_SEND_RUN : c_FETCH;
            c_SEND_RUN:   if (w_cmd_fire) w_state_nxt = c_WAIT_RES;
            c_WAIT_RES:   if (w_res_take || w_tmo) w_state_nxt = c_DONE;
            c_DONE:       w_state_nxt = c_IDLE;
            default:      w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------ message build
    always_comb begin
        w_fval = '0;
        w_msg  = '0;
        case (r_fld)
            2'd0:    w_fval = W_REWARD'(r_par);
            2'd1:    w_fval = r_rew;
            2'd2:    w_fval = W_REWARD'(r_act);
            default: w_fval = r_wgt;
        endcase
        case (r_state)
            c_SEND_CFG: begin
                w_msg[W_MSG-1 -: 2]  = c_CMD_CFG;
                w_msg[W_ADDR-1:0]    = r_num;
            end
            c_SEND_FIELD: begin
                w_msg[W_MSG-1 -: 2]        = c_CMD_NODE;
                w_msg[W_MSG-3 -: W_ADDR]   = r_idx;
                w_msg[W_MSG-3-W_ADDR -: 2] = r_fld;
                w_msg[W_REWARD-1:0]        = w_fval;
            end
            default: w_msg[W_MSG-1 -: 2] = c_CMD_RUN;
        endcase
    end

    // ------------------------------------------------ sequencing datapath
    // A send state spends one cycle with cmd_rdy low loading the message,
    // then holds cmd_rdy high until acked; the same state re-arms for the
    // next field, so every message costs at least two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num     <= '0;
            r_idx     <= '0;
            r_fld     <= '0;
            r_par     <= '0;
            r_rew     <= '0;
            r_act     <= '0;
            r_wgt     <= '0;
            r_cmd_msg <= '0;
            r_cmd_rdy <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && start) begin
                r_num <= num_nodes;
                r_idx <= '0;
            end
            if (r_state == c_LATCH) begin
                r_par <= node_par;
                r_rew <= node_rew;
                r_act <= node_act;
                r_wgt <= node_wgt;
                r_fld <= 2'd0;
            end
            if (w_send_st && !r_cmd_rdy) begin
                r_cmd_rdy <= 1'b1;
                r_cmd_msg <= w_msg;
            end else if (w_cmd_fire) begin
                r_cmd_rdy <= 1'b0;
                if (r_state == c_SEND_FIELD) begin
                    r_fld <= r_fld + 2'd1;
                    if ((r_fld == 2'd3) && !w_last) r_idx <= r_idx + W_ADDR'(1);
                end
            end
        end
    end

    // ------------------------------------------------- result and timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_ack <= 1'b0;
            r_res_act <= '0;
            r_res_rew <= '0;
            r_err     <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_res_ack <= w_res_take;
            if (w_res_take) begin
                r_res_act <= res_msg[W_ACTION+W_REWARD-1:W_REWARD];
                r_res_rew <= res_msg[W_REWARD-1:0];
            end
            if ((r_state == c_IDLE) && start) r_err <= 1'b0;
            else if (w_tmo)                   r_err <= 1'b1;
            r_tcnt <= (r_state == c_WAIT_RES) ? r_tcnt + c_TW'(1) : '0;
        end
    end

    assign node_rd_en   = (r_state == c_FETCH);
    assign node_rd_addr = r_idx;
    assign cmd_msg      = r_cmd_msg;
    assign cmd_rdy      = r_cmd_rdy;
    assign res_ack      = r_res_ack;
    assign busy         = (r_state != c_IDLE);
    assign done         = (r_state == c_DONE);
    assign err          = r_err;
    assign result_act   = r_res_act;
    assign result_rew   = r_res_rew;

endmodule
`default_nettype wire

// File: tb/tb_treeval_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_treeval_cmd_issuer
// Purpose  : Self-checking bench for treeval_cmd_issuer. A node-table RAM
//            model feeds the DUT; the expected message stream is built from
//            the table, the result model from the injected result message.
// Revision : 1.0 - initial release
// ============================================================================
module tb_treeval_cmd_issuer;

    localparam int W_MSG    = 64;
    localparam int W_ADDR   = 10;
    localparam int W_REWARD = 10;
    localparam int W_ACTION = 3;
    localparam int TIMEOUT  = 16;

    logic                clk;
    logic                rst;
    logic                start;
    logic [W_ADDR-1:0]   num_nodes;
    logic                node_rd_en;
    logic [W_ADDR-1:0]   node_rd_addr;
    logic [W_ADDR-1:0]   node_par;
    logic [W_REWARD-1:0] node_rew;
    logic [W_ACTION-1:0] node_act;
    logic [W_REWARD-1:0] node_wgt;
    logic [W_MSG-1:0]    cmd_msg;
    logic                cmd_rdy;
    logic                cmd_ack;
    logic [W_MSG-1:0]    res_msg;
    logic                res_rdy;
    logic                res_ack;
    logic                busy;
    logic                done;
    logic                err;
    logic [W_ACTION-1:0] result_act;
    logic [W_REWARD-1:0] result_rew;

    treeval_cmd_issuer #(
        .W_MSG(W_MSG), .W_ADDR(W_ADDR), .W_REWARD(W_REWARD),
        .W_ACTION(W_ACTION), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .num_nodes(num_nodes),
        .node_rd_en(node_rd_en), .node_rd_addr(node_rd_addr),
        .node_par(node_par), .node_rew(node_rew), .node_act(node_act),
        .node_wgt(node_wgt), .cmd_msg(cmd_msg), .cmd_rdy(cmd_rdy),
        .cmd_ack(cmd_ack), .res_msg(res_msg), .res_rdy(res_rdy),
        .res_ack(res_ack), .busy(busy), .done(done), .err(err),
        .result_act(result_act), .result_rew(result_rew)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Node-table RAM: one-cycle read latency, garbage when not read.
    logic [9:0] t_par [0:1023];
    logic [9:0] t_rew [0:1023];
    logic [2:0] t_act [0:1023];
    logic [9:0] t_wgt [0:1023];

    always @(posedge clk) begin
        if (node_rd_en) begin
            node_par <= t_par[node_rd_addr];
            node_rew <= t_rew[node_rd_addr];
            node_act <= t_act[node_rd_addr];
            node_wgt <= t_wgt[node_rd_addr];
        end else begin
            node_par <= 10'($urandom);
            node_rew <= 10'($urandom);
            node_act <= 3'($urandom);
            node_wgt <= 10'($urandom);
        end
    end

    int          n_chk;
    int          n_err;
    logic [63:0] exp_q [$];
    logic [2:0]  m_act;
    logic [9:0]  m_rew;
    logic [63:0] rnd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] node_msg(input int a, input int f, input logic [9:0] v);
        return (64'd1 << 62) | (64'(a) << 52) | (64'(f) << 50) | 64'(v);
    endfunction

    task automatic fill_table(input int n);
        for (int i = 0; i < n; i++) begin
            t_par[i] = 10'($urandom);
            t_rew[i] = 10'($urandom);
            t_act[i] = 3'($urandom);
            t_wgt[i] = 10'($urandom);
        end
    endtask

    task automatic zero_outs(input string pfx);
        chk({pfx, "_cmd_rdy"}, 64'(cmd_rdy), 64'd0);
        chk({pfx, "_cmd_msg"}, cmd_msg, 64'd0);
        chk({pfx, "_flags"}, 64'({busy, done, err, res_ack, node_rd_en}), 64'd0);
        chk({pfx, "_rd_addr"}, 64'(node_rd_addr), 64'd0);
        chk({pfx, "_result"}, 64'({result_act, result_rew}), 64'd0);
    endtask

    // One full sequence: n nodes, ack probability ack_pct, ack withheld
    // 5 cycles on message index wh, result offered (res_on) or not.
    task automatic run_seq(input int n, input int ack_pct, input int wh,
                           input bit res_on, input bit tmo_exp, input logic [63:0] rmsg);
        int cyc, sent, wcnt, unstable, early, extra, dones, acks;
        int run_at, done_at, busy_post, budget;
        bit hold;
        logic [63:0] held;
        cyc = 0; sent = 0; wcnt = 0; unstable = 0; early = 0; extra = 0;
        dones = 0; acks = 0; run_at = -1; done_at = -1; busy_post = 0;
        hold = 1'b0; held = '0;
        budget = 40 * n + 200;

        exp_q.delete();
        exp_q.push_back((64'd2 << 62) | 64'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(node_msg(i, 0, t_par[i]));
            exp_q.push_back(node_msg(i, 1, t_rew[i]));
            exp_q.push_back(node_msg(i, 2, 10'(t_act[i])));
            exp_q.push_back(node_msg(i, 3, t_wgt[i]));
        end
        exp_q.push_back(64'd0);

        res_msg   = rmsg;
        res_rdy   = res_on;
        num_nodes = 10'(n);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        num_nodes = 10'($urandom);
        chk("busy_after_start", 64'(busy), 64'd1);

        while (cyc < budget) begin
            if (hold && (cmd_rdy !== 1'b1 || cmd_msg !== held)) unstable++;
            if (res_ack) begin
                acks++;
                if (exp_q.size() != 0) early++;
            end
            if (done) begin
                dones++;
                done_at = cyc;
            end
            // Starts while busy (and in the DONE cycle) must be ignored.
            start   = done || ($urandom_range(0, 99) < 3);
            cmd_ack = ($urandom_range(0, 99) < ack_pct);
            if (cmd_rdy && sent == wh && wcnt < 5) begin
                cmd_ack = 1'b0;
                wcnt++;
            end
            if (cmd_rdy && cmd_ack) begin
                sent++;
                hold = 1'b0;
                if (exp_q.size() == 0) extra++;
                else begin
                    chk("cmd_msg", cmd_msg, exp_q.pop_front());
                    if (exp_q.size() == 0) run_at = cyc;
                end
            end else begin
                hold = cmd_rdy;
                held = cmd_msg;
            end
            @(negedge clk);
            cyc++;
            if (dones != 0) break;
        end
        start   = 1'b0;
        cmd_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            if (res_ack) acks++;
            if (busy) busy_post++;
            @(negedge clk);
        end

        chk("msgs_missing", 64'(exp_q.size()), 64'd0);
        chk("msgs_extra", 64'(extra), 64'd0);
        chk("msg_unstable", 64'(unstable), 64'd0);
        chk("res_ack_early", 64'(early), 64'd0);
        chk("done_pulses", 64'(dones), 64'd1);
        chk("res_ack_pulses", 64'(acks), tmo_exp ? 64'd0 : 64'd1);
        chk("busy_after_done", 64'(busy_post), 64'd0);
        chk("err", 64'(err), 64'(tmo_exp));
        if (!tmo_exp) begin
            m_act = 3'((rmsg >> 10) & 64'h7);
            m_rew = 10'(rmsg & 64'h3FF);
        end else begin
            // DONE appears TIMEOUT cycles after WAIT_RES entry, which is one
            // cycle after the RUN handshake.
            chk("timeout_latency", 64'(done_at - run_at), 64'(TIMEOUT + 1));
        end
        chk("result_act", 64'(result_act), 64'(m_act));
        chk("result_rew", 64'(result_rew), 64'(m_rew));
    endtask

    initial begin
        int n, cnt, guard;
        n_chk = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; num_nodes = '0; cmd_ack = 1'b0;
        res_msg = '0; res_rdy = 1'b0; m_act = '0; m_rew = '0;
        repeat (3) @(negedge clk);
        zero_outs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Empty table: config(0) then RUN, result 0x1405 -> act 5, rew 5.
        run_seq(0, 100, -1, 1'b1, 1'b0, 64'h1405);

        // Two nodes with node1 = {par 0, rew -3, act 2, wgt 7}.
        fill_table(2);
        t_par[1] = 10'd0; t_rew[1] = 10'h3FD; t_act[1] = 3'd2; t_wgt[1] = 10'd7;
        rnd = {$urandom, $urandom};
        run_seq(2, 100, -1, 1'b1, 1'b0, rnd);

        // Random acks with the third message withheld for 5 cycles.
        fill_table(5);
        rnd = {$urandom, $urandom};
        run_seq(5, 50, 2, 1'b1, 1'b0, rnd);

        // No result: timeout, err held, result registers unchanged.
        fill_table(1);
        run_seq(1, 100, -1, 1'b0, 1'b1, {$urandom, $urandom});
        repeat (5) @(negedge clk);
        chk("err_held", 64'(err), 64'd1);
        chk("result_act_held", 64'(result_act), 64'(m_act));
        chk("result_rew_held", 64'(result_rew), 64'(m_rew));

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 20);
            fill_table(n);
            rnd = {$urandom, $urandom};
            run_seq(n, 60, -1, 1'b1, 1'b0, rnd);
        end

        // Reset while a mid-node message is pending.
        fill_table(3);
        res_rdy = 1'b0; cmd_ack = 1'b1; num_nodes = 10'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cnt = 0; guard = 0;
        while (!(cnt >= 6 && cmd_rdy) && guard < 200) begin
            if (cmd_rdy) cnt++;
            @(negedge clk);
            guard++;
        end
        chk("mid_cmd_rdy", 64'(cmd_rdy), 64'd1);
        #1 rst = 1'b1;
        #1;
        zero_outs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; cmd_ack = 1'b0;
        m_act = '0; m_rew = '0;
        @(negedge clk);
        run_seq(3, 100, -1, 1'b1, 1'b0, {$urandom, $urandom});

        // Largest node count.
        fill_table(1023);
        run_seq(1023, 100, -1, 1'b1, 1'b0, {$urandom, $urandom});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
